// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the video RAM arbiter.
// owner_t tags each RAM access so its read data can be returned to the right requester.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

    // Bits needed to hold 0..v. Never returns less than 1.
    function automatic int clog2_sat(input int v);
        int w;
        w = $clog2(v + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vram_rtag_pipe.sv
// Owner-tag shift register that follows each RAM access down the read pipeline.
// Captures RAM read data into the owner's RDATA register and pulses that owner's RVALID.
module vram_rtag_pipe
    import vram_arb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              srst,
    input  owner_t            tag_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata
);

    localparam int DEPTH = RAM_LATENCY + 1;

    owner_t            tag_reg  [DEPTH];
    owner_t            tag_next [DEPTH];
    owner_t            tag_out;
    logic              vid_rvalid_reg;
    logic              cpu_rvalid_reg;
    logic [DATA_W-1:0] vid_rdata_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;

    // Stage k holds the tag of the access issued k+1 cycles ago.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign tag_next[gi] = tag_in;
            end else begin : g_body
                assign tag_next[gi] = tag_reg[gi-1];
            end
        end
    endgenerate

    // The last stage lines up with the cycle RAM_RDATA is valid.
    assign tag_out = tag_reg[DEPTH-1];

    always_ff @(posedge clk) begin
        if (srst) begin
            tag_reg        <= '{default: OWN_NONE};
            vid_rvalid_reg <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            vid_rdata_reg  <= '0;
            cpu_rdata_reg  <= '0;
        end else begin
            tag_reg        <= tag_next;
            vid_rvalid_reg <= (tag_out == OWN_VID);
            cpu_rvalid_reg <= (tag_out == OWN_CPU);
            if (tag_out == OWN_VID) begin
                vid_rdata_reg <= ram_rdata;
            end
            if (tag_out == OWN_CPU) begin
                cpu_rdata_reg <= ram_rdata;
            end
        end
    end

    assign vid_rvalid = vid_rvalid_reg;
    assign vid_rdata  = vid_rdata_reg;
    assign cpu_rvalid = cpu_rvalid_reg;
    assign cpu_rdata  = cpu_rdata_reg;

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port video RAM between the CPU bus and the CRT scan-fetch unit.
// Video has fixed priority; a starvation counter forces the CPU through after STARVE_LIMIT waits.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RAM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK_40MHZ,
    input  logic              RESET,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic              VID_ACK,
    output logic              VID_RVALID,
    output logic [DATA_W-1:0] VID_RDATA,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_ACK,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA
);

    localparam int               CNT_W   = clog2_sat(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt_reg;
    logic [CNT_W-1:0]  starve_cnt_next;
    logic              force_cpu;
    logic              cpu_ack;
    logic              vid_ack;
    owner_t            tag_in;

    logic              ram_en_reg;
    logic              ram_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;

    logic              vid_wait_reg;
    logic              cpu_wait_reg;
    logic [ADDR_W-1:0] vid_addr_hold_reg;
    logic [ADDR_W-1:0] cpu_addr_hold_reg;
    logic [DATA_W-1:0] cpu_wdata_hold_reg;
    logic              cpu_we_hold_reg;

    always_comb begin
        force_cpu = CPU_REQ && (starve_cnt_reg == LIMIT_C);
        cpu_ack   = !RESET && CPU_REQ && (force_cpu || !VID_REQ);
        vid_ack   = !RESET && VID_REQ && !cpu_ack;

        starve_cnt_next = starve_cnt_reg;
        if (!CPU_REQ || cpu_ack) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != LIMIT_C) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end

        // CPU writes return nothing, so they travel down the pipe as OWN_NONE.
        tag_in = OWN_NONE;
        if (cpu_ack && !CPU_WE) begin
            tag_in = OWN_CPU;
        end else if (vid_ack) begin
            tag_in = OWN_VID;
        end
    end

    always_ff @(posedge CLK_40MHZ) begin
        if (RESET) begin
            starve_cnt_reg <= '0;
            ram_en_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            ram_en_reg     <= cpu_ack || vid_ack;
            ram_we_reg     <= cpu_ack && CPU_WE;
            if (cpu_ack) begin
                ram_addr_reg  <= CPU_ADDR;
                ram_wdata_reg <= CPU_WDATA;
            end else if (vid_ack) begin
                ram_addr_reg  <= VID_ADDR;
            end
        end
    end

    // Simulation-only guard: a waiting requester must keep its command stable.
    always_ff @(posedge CLK_40MHZ) begin
        if (RESET) begin
            vid_wait_reg <= 1'b0;
            cpu_wait_reg <= 1'b0;
        end else begin
            if (vid_wait_reg && VID_REQ) begin
                assert (VID_ADDR == vid_addr_hold_reg);
            end
            if (cpu_wait_reg && CPU_REQ) begin
                assert ((CPU_ADDR == cpu_addr_hold_reg) && (CPU_WE == cpu_we_hold_reg)
                        && (CPU_WDATA == cpu_wdata_hold_reg));
            end
            vid_wait_reg <= VID_REQ && !vid_ack;
            cpu_wait_reg <= CPU_REQ && !cpu_ack;
        end
        vid_addr_hold_reg  <= VID_ADDR;
        cpu_addr_hold_reg  <= CPU_ADDR;
        cpu_we_hold_reg    <= CPU_WE;
        cpu_wdata_hold_reg <= CPU_WDATA;
    end

    vram_rtag_pipe #(
        .DATA_W      (DATA_W),
        .RAM_LATENCY (RAM_LATENCY)
    ) u_rtag_pipe (
        .clk        (CLK_40MHZ),
        .srst       (RESET),
        .tag_in     (tag_in),
        .ram_rdata  (RAM_RDATA),
        .vid_rvalid (VID_RVALID),
        .vid_rdata  (VID_RDATA),
        .cpu_rvalid (CPU_RVALID),
        .cpu_rdata  (CPU_RDATA)
    );

    assign VID_ACK   = vid_ack;
    assign CPU_ACK   = cpu_ack;
    assign RAM_EN    = ram_en_reg;
    assign RAM_WE    = ram_we_reg;
    assign RAM_ADDR  = ram_addr_reg;
    assign RAM_WDATA = ram_wdata_reg;

endmodule
